// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port register-file RAM by two requesters.
// Define ARB_LOCK_EN to add per-port lock ownership with a 16-cycle idle timeout.
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
`ifdef ARB_LOCK_EN
    input  logic              a_lock,
    input  logic              b_lock,
`endif
    output logic [CNT_W-1:0]  conflict_cnt,
    input  logic              conflict_clr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rr_pri_b;
    logic              block_a;
    logic              block_b;
    logic              both_req;

    logic              acc_go;
    logic              acc_we;
    logic              acc_hit;
    logic [ADDR_W-1:0] acc_addr;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] acc_rword;

    assign both_req = a_req & b_req;

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_e;

    owner_e     owner_q;
    owner_e     owner_d;
    logic [3:0] idle_q;
    logic [3:0] idle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            idle_q  <= '0;
        end else begin
            owner_q <= owner_d;
            idle_q  <= idle_d;
        end
    end

    // Idle counter only runs while the owner is not requesting.
    always_comb begin
        owner_d = owner_q;
        idle_d  = '0;
        unique case (owner_q)
            OWN_NONE: begin
                if (a_gnt && a_lock) begin
                    owner_d = OWN_A;
                end else if (b_gnt && b_lock) begin
                    owner_d = OWN_B;
                end
            end
            OWN_A: begin
                if (a_req) begin
                    if (a_gnt && !a_lock) begin
                        owner_d = OWN_NONE;
                    end
                end else if (idle_q == 4'hF) begin
                    owner_d = OWN_NONE;
                end else begin
                    idle_d = idle_q + 4'd1;
                end
            end
            OWN_B: begin
                if (b_req) begin
                    if (b_gnt && !b_lock) begin
                        owner_d = OWN_NONE;
                    end
                end else if (idle_q == 4'hF) begin
                    owner_d = OWN_NONE;
                end else begin
                    idle_d = idle_q + 4'd1;
                end
            end
            default: begin
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        block_a = (owner_q == OWN_B);
        block_b = (owner_q == OWN_A);
    end
`else
    assign block_a = 1'b0;
    assign block_b = 1'b0;
`endif

    // A blocked competitor is treated as absent from the contest.
    always_comb begin
        a_gnt = a_req & ~block_a & (~b_req | block_b | ~rr_pri_b);
        b_gnt = b_req & ~block_b & (~a_req | block_a | rr_pri_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_pri_b <= 1'b0;
        end else if (both_req) begin
            rr_pri_b <= a_gnt;
        end
    end

    always_comb begin
        acc_go    = a_gnt | b_gnt;
        acc_we    = a_gnt ? a_we    : b_we;
        acc_addr  = a_gnt ? a_addr  : b_addr;
        acc_wdata = a_gnt ? a_wdata : b_wdata;
        acc_hit   = ({1'b0, acc_addr} < DEPTH_V);
        acc_idx   = acc_addr[IDX_W-1:0];
        acc_rword = acc_hit ? mem[acc_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (acc_go && acc_we && acc_hit) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= acc_rword;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= acc_rword;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict_clr) begin
            conflict_cnt <= '0;
        end else if (both_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter.
// DUT built with ADDR_W=7, DEPTH=64 so addresses 64..127 are out of range.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int DP = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [CW-1:0] conflict_cnt;
    logic          conflict_clr;
`ifdef ARB_LOCK_EN
    logic          a_lock, b_lock;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [DP];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    ram_port_arbiter #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DP),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_gnt       (a_gnt),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_gnt       (b_gnt),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
`ifdef ARB_LOCK_EN
        .a_lock      (a_lock),
        .b_lock      (b_lock),
`endif
        .conflict_cnt(conflict_cnt),
        .conflict_clr(conflict_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: expectations pushed at grant, popped at rvalid.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            checks++;
            if (a_gnt && b_gnt) begin
                errors++;
                $display("FAIL gnt_excl: a_gnt=%b b_gnt=%b, required not both", a_gnt, b_gnt);
            end
            if (a_rvalid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_rvalid_spurious: a_rvalid=1, required 0");
                end else if (a_rdata !== qa[0]) begin
                    errors++;
                    $display("FAIL a_rdata_sb: got %h, required %h", a_rdata, qa[0]);
                    void'(qa.pop_front());
                end else begin
                    void'(qa.pop_front());
                end
            end else if (qa.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL a_rvalid_missing: a_rvalid=0, required 1");
                qa.delete();
            end
            if (b_rvalid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_rvalid_spurious: b_rvalid=1, required 0");
                end else if (b_rdata !== qb[0]) begin
                    errors++;
                    $display("FAIL b_rdata_sb: got %h, required %h", b_rdata, qb[0]);
                    void'(qb.pop_front());
                end else begin
                    void'(qb.pop_front());
                end
            end else if (qb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL b_rvalid_missing: b_rvalid=0, required 1");
                qb.delete();
            end
            if (a_gnt) begin
                if (a_we) begin
                    if (a_addr < AW'(DP)) mdl[a_addr[5:0]] = a_wdata;
                end else begin
                    qa.push_back((a_addr < AW'(DP)) ? mdl[a_addr[5:0]] : '0);
                end
            end
            if (b_gnt) begin
                if (b_we) begin
                    if (b_addr < AW'(DP)) mdl[b_addr[5:0]] = b_wdata;
                end else begin
                    qb.push_back((b_addr < AW'(DP)) ? mdl[b_addr[5:0]] : '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic br, input logic bw,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: a=%b b=%b, required 0 0", a_rvalid, b_rvalid);
        end
        checks++;
        if (a_rdata !== '0 || b_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: a=%h b=%h, required 00 00", a_rdata, b_rdata);
        end
        checks++;
        if (conflict_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %h, required 0000", conflict_cnt);
        end
    endtask

    task automatic test_write_read();
        tick(); drive(1, 1, 7'd5, 8'hA5, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt: a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
        end
        tick(); drive(1, 0, 7'd5, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_gnt: a_gnt=%b a_rvalid=%b, required 1 0", a_gnt, a_rvalid);
        end
        tick(); drive(0, 0, 0, 0, 1, 1, 7'd7, 8'h77);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_data: rvalid=%b rdata=%h, required 1 a5", a_rvalid, a_rdata);
        end
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b_wr_gnt: b_gnt=%b, required 1", b_gnt);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rvalid_pulse: rvalid=%b rdata=%h, required 0 a5", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            tick(); drive(1, 0, 7'd5, 0, 1, 0, 7'd7, 0);
            @(negedge clk);
            checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: a=%b b=%b, required %b %b", i, a_gnt, b_gnt,
                         (i % 2 == 0), (i % 2 == 1));
            end
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'd6) begin
            errors++;
            $display("FAIL rr_cnt: got %0d, required 6", conflict_cnt);
        end
    endtask

    task automatic test_same_addr();
        tick(); drive(1, 0, 7'd5, 0, 1, 0, 7'd7, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL sa_setup: a_gnt=%b, required 1", a_gnt);
        end
        tick(); drive(1, 0, 7'd63, 0, 1, 1, 7'd63, 8'h3C);
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL sa_first: a=%b b=%b, required 0 1", a_gnt, b_gnt);
        end
        tick(); drive(1, 0, 7'd63, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL sa_second: a_gnt=%b, required 1", a_gnt);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL sa_data: rvalid=%b rdata=%h, required 1 3c", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_out_of_range();
        tick(); drive(1, 1, 7'd69, 8'hEE, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL oor_wr_gnt: a_gnt=%b, required 1", a_gnt);
        end
        tick(); drive(1, 0, 7'd69, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick(); drive(1, 0, 7'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL oor_rd: rvalid=%b rdata=%h, required 1 00", a_rvalid, a_rdata);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL oor_alias: rdata=%h, required a5", a_rdata);
        end
    endtask

    task automatic test_saturate();
        tick(); conflict_clr = 1'b1;
        tick(); conflict_clr = 1'b0;
        drive(1, 1, 7'd10, 8'h10, 1, 1, 7'd11, 8'h11);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_fffe: got %h, required fffe", conflict_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (conflict_cnt !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_hold[%0d]: got %h, required ffff", k, conflict_cnt);
            end
        end
        tick(); conflict_clr = 1'b1;
        @(negedge clk);
        tick(); conflict_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (conflict_cnt !== '0) begin
            errors++;
            $display("FAIL sat_clr: got %h, required 0000", conflict_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tick(); drive(1, 0, 7'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_gnt: a_gnt=%b, required 1", a_gnt);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== '0) begin
            errors++;
            $display("FAIL rm_clear: rvalid=%b rdata=%h, required 0 00", a_rvalid, a_rdata);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(); drive(1, 0, 7'd7, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_regnt: gnt=%b rvalid=%b, required 1 0", a_gnt, a_rvalid);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h77) begin
            errors++;
            $display("FAIL rm_data: rvalid=%b rdata=%h, required 1 77", a_rvalid, a_rdata);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock_burst();
        for (int i = 0; i < 4; i++) begin
            tick(); drive(1, 1, AW'(20 + i), DW'(8'h50 + i), 1, 0, 7'd5, 0);
            a_lock = (i < 3);
            @(negedge clk);
            checks++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                errors++;
                $display("FAIL lock_beat[%0d]: a=%b b=%b, required 1 0", i, a_gnt, b_gnt);
            end
        end
        tick(); drive(0, 0, 0, 0, 1, 0, 7'd5, 0);
        a_lock = 1'b0;
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: b_gnt=%b, required 1", b_gnt);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_lock_timeout();
        tick(); drive(1, 0, 7'd5, 0, 0, 0, 0, 0);
        a_lock = 1'b1;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lto_gnt: a_gnt=%b, required 1", a_gnt);
        end
        for (int i = 0; i < 16; i++) begin
            tick(); drive(0, 0, 0, 0, 1, 0, 7'd7, 0);
            a_lock = 1'b0;
            @(negedge clk);
            checks++;
            if (b_gnt !== 1'b0) begin
                errors++;
                $display("FAIL lto_block[%0d]: b_gnt=%b, required 0", i, b_gnt);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lto_expire: b_gnt=%b, required 1", b_gnt);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        conflict_clr = 1'b0;
`ifdef ARB_LOCK_EN
        a_lock = 1'b0;
        b_lock = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_write_read();
        test_round_robin();
        test_same_addr();
        test_out_of_range();
        test_saturate();
        test_reset_mid();
`ifdef ARB_LOCK_EN
        test_lock_burst();
        test_lock_timeout();
`endif
        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
